// File: rtl/key_conditioner.sv
// key_conditioner: conditions one raw active-low pushbutton.
// The chain is a two-flop synchronizer, then a debounce FSM with saturating
// counters, then registered one-cycle press/release/repeat strobes.
module key_conditioner #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter bit REPEAT_EN       = 1'b1,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000
) (
    input  logic clk,
    input  logic reset,
    input  logic key_n,
    output logic held,
    output logic press_pulse,
    output logic release_pulse,
    output logic repeat_pulse,
    output logic key_event
);

    // One counter width covers both counters, so it is sized for the largest parameter.
    localparam int MAX_A = (DEBOUNCE_CYCLES > REPEAT_DELAY) ? DEBOUNCE_CYCLES : REPEAT_DELAY;
    localparam int MAX_P = (MAX_A > REPEAT_PERIOD) ? MAX_A : REPEAT_PERIOD;
    localparam int CW    = $clog2(MAX_P) + 1;

    localparam logic [CW-1:0] DB_LAST      = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] RPT_DLY_LAST = CW'(REPEAT_DELAY - 1);
    localparam logic [CW-1:0] RPT_PER_LAST = CW'(REPEAT_PERIOD - 1);
    localparam logic [CW-1:0] CNT_ONE      = CW'(1);
    localparam logic [CW-1:0] CNT_ZERO     = CW'(0);

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        HELD         = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic            sync1_q, sync1_d;
    logic            sync2_q, sync2_d;
    logic [CW-1:0]   db_cnt_q, db_cnt_d;
    logic [CW-1:0]   rpt_cnt_q, rpt_cnt_d;
    logic            first_rpt_q, first_rpt_d;
    logic            held_q, held_d;
    logic            press_q, press_d;
    logic            release_q, release_d;
    logic            repeat_q, repeat_d;
    logic            event_q, event_d;
    logic [CW-1:0]   rpt_thr_s;

    // The first repeat waits the long delay, later ones the short period.
    assign rpt_thr_s = first_rpt_q ? RPT_DLY_LAST : RPT_PER_LAST;

    // Next-state logic: synchronizer shift, debounce FSM, repeat timer and strobes.
    always_comb begin
        sync1_d     = key_n;
        sync2_d     = sync1_q;
        state_d     = state_q;
        db_cnt_d    = db_cnt_q;
        rpt_cnt_d   = rpt_cnt_q;
        first_rpt_d = first_rpt_q;
        press_d     = 1'b0;
        release_d   = 1'b0;
        repeat_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (!sync2_q) begin
                    state_d  = PRESS_WAIT;
                    db_cnt_d = CNT_ONE;
                end else begin
                    db_cnt_d = CNT_ZERO;
                end
            end
            PRESS_WAIT: begin
                if (sync2_q) begin
                    state_d  = IDLE;
                    db_cnt_d = CNT_ZERO;
                end else if (db_cnt_q >= DB_LAST) begin
                    state_d     = HELD;
                    press_d     = 1'b1;
                    rpt_cnt_d   = CNT_ZERO;
                    first_rpt_d = 1'b1;
                end else begin
                    db_cnt_d = db_cnt_q + CNT_ONE;
                end
            end
            HELD: begin
                if (sync2_q) begin
                    // rpt_cnt is left untouched so a release bounce resumes the timing
                    state_d  = RELEASE_WAIT;
                    db_cnt_d = CNT_ONE;
                end else if (REPEAT_EN) begin
                    if (rpt_cnt_q >= rpt_thr_s) begin
                        repeat_d    = 1'b1;
                        rpt_cnt_d   = CNT_ZERO;
                        first_rpt_d = 1'b0;
                    end else begin
                        rpt_cnt_d = rpt_cnt_q + CNT_ONE;
                    end
                end else begin
                    rpt_cnt_d = CNT_ZERO;
                end
            end
            RELEASE_WAIT: begin
                if (!sync2_q) begin
                    state_d = HELD;
                end else if (db_cnt_q >= DB_LAST) begin
                    state_d   = IDLE;
                    release_d = 1'b1;
                    db_cnt_d  = CNT_ZERO;
                end else begin
                    db_cnt_d = db_cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d     = IDLE;
                db_cnt_d    = CNT_ZERO;
                rpt_cnt_d   = CNT_ZERO;
                first_rpt_d = 1'b1;
            end
        endcase

        held_d  = (state_d == HELD) || (state_d == RELEASE_WAIT);
        event_d = press_d | repeat_d;
    end

    // State and output registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q     <= 1'b1;
            sync2_q     <= 1'b1;
            state_q     <= IDLE;
            db_cnt_q    <= CNT_ZERO;
            rpt_cnt_q   <= CNT_ZERO;
            first_rpt_q <= 1'b1;
            held_q      <= 1'b0;
            press_q     <= 1'b0;
            release_q   <= 1'b0;
            repeat_q    <= 1'b0;
            event_q     <= 1'b0;
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            state_q     <= state_d;
            db_cnt_q    <= db_cnt_d;
            rpt_cnt_q   <= rpt_cnt_d;
            first_rpt_q <= first_rpt_d;
            held_q      <= held_d;
            press_q     <= press_d;
            release_q   <= release_d;
            repeat_q    <= repeat_d;
            event_q     <= event_d;
        end
    end

    assign held          = held_q;
    assign press_pulse   = press_q;
    assign release_pulse = release_q;
    assign repeat_pulse  = repeat_q;
    assign key_event     = event_q;

endmodule

// File: tb/tb_key_conditioner.sv
// Bench for key_conditioner: two instances (auto-repeat on and off) share
// one key input; a run-length reference model predicts every output.
module tb_key_conditioner;

    localparam int D  = 4;
    localparam int RD = 10;
    localparam int RP = 3;

    logic clk = 1'b0;
    logic reset;
    logic key_n;

    logic held1, press1, rel1, rep1, ev1;
    logic held0, press0, rel0, rep0, ev0;

    key_conditioner #(
        .DEBOUNCE_CYCLES(D), .REPEAT_EN(1'b1), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
    ) dut1 (
        .clk(clk), .reset(reset), .key_n(key_n),
        .held(held1), .press_pulse(press1), .release_pulse(rel1),
        .repeat_pulse(rep1), .key_event(ev1)
    );

    key_conditioner #(
        .DEBOUNCE_CYCLES(D), .REPEAT_EN(1'b0), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
    ) dut0 (
        .clk(clk), .reset(reset), .key_n(key_n),
        .held(held0), .press_pulse(press0), .release_pulse(rel0),
        .repeat_pulse(rep0), .key_event(ev0)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    // Reference model: the accepted level flips after D consecutive
    // synchronized samples disagreeing with it; while pressed, each
    // pressed sample taken with no pending release counts toward repeat.
    bit m_s1 = 1'b1;
    bit m_s2 = 1'b1;
    bit m_acc = 1'b0;
    int m_run = 0;
    int m_n = 0;
    bit m_first = 1'b1;
    bit e_press = 1'b0;
    bit e_rel = 1'b0;
    bit e_rep = 1'b0;

    always @(posedge clk) begin
        bit smp_pressed;
        if (reset) begin
            m_s1 = 1'b1; m_s2 = 1'b1; m_acc = 1'b0;
            m_run = 0; m_n = 0; m_first = 1'b1;
            e_press = 1'b0; e_rel = 1'b0; e_rep = 1'b0;
        end else begin
            smp_pressed = (m_s2 == 1'b0);
            m_s2 = m_s1;
            m_s1 = key_n;
            e_press = 1'b0; e_rel = 1'b0; e_rep = 1'b0;
            if (smp_pressed != m_acc) begin
                m_run++;
                if (m_run == D) begin
                    m_acc = smp_pressed;
                    m_run = 0;
                    if (m_acc) begin
                        e_press = 1'b1; m_n = 0; m_first = 1'b1;
                    end else begin
                        e_rel = 1'b1;
                    end
                end
            end else if (m_acc) begin
                if (m_run != 0) begin
                    m_run = 0;
                end else begin
                    m_n++;
                    if (m_n == (m_first ? RD : RP)) begin
                        e_rep = 1'b1; m_n = 0; m_first = 1'b0;
                    end
                end
            end else begin
                m_run = 0;
            end
        end
    end

    task automatic check(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: actual=%b required=%b", name, $time, act, exp);
        end
    endtask

    // Every-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            check("held",          held1,  m_acc);
            check("press",         press1, e_press);
            check("release",       rel1,   e_rel);
            check("repeat",        rep1,   e_rep);
            check("key_event",     ev1,    e_press | e_rep);
            check("held_norpt",    held0,  m_acc);
            check("press_norpt",   press0, e_press);
            check("release_norpt", rel0,   e_rel);
            check("repeat_norpt",  rep0,   1'b0);
            check("event_norpt",   ev0,    e_press);
        end
    end

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1;
        key_n = 1'b1;
        @(posedge clk);
        chk_en = 1'b1;
        @(negedge clk);

        // Reset held for two cycles with the key pressed
        key_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            check("lit_rst_held", held1, 1'b0);
            check("lit_rst_press", press1, 1'b0);
        end
        reset = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            step();
            check("lit_rst_press_seq", press1, (i == 6));
            check("lit_rst_held_seq", held1, (i == 6));
            if (i == 6) check("lit_model_press", e_press, 1'b1);
        end
        key_n = 1'b1;
        repeat (12) step();

        // Clean press then 40+ cycles of hold: press at 6, repeats at 16,19,...
        key_n = 1'b0;
        for (int i = 1; i <= 46; i++) begin
            step();
            check("lit_cp_press", press1, (i == 6));
            check("lit_cp_event", ev1, (i == 6) || (i >= 16 && (i - 16) % 3 == 0));
            check("lit_cp_model_rep", e_rep, (i >= 16 && (i - 16) % 3 == 0));
            check("lit_cp_norpt", rep0, 1'b0);
        end

        // Release bounce: high 2, low 1, then steady high
        key_n = 1'b1; step(); check("lit_rb_blip", rel1, 1'b0);
        step(); check("lit_rb_blip", rel1, 1'b0);
        key_n = 1'b0; step(); check("lit_rb_blip", rel1, 1'b0);
        key_n = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            step();
            check("lit_rb_release", rel1, (i == 6));
            check("lit_rb_held", held1, (i != 6));
        end
        repeat (8) step();

        // Press bounce: low 3, high 1, low 3, high
        key_n = 1'b0; repeat (3) step();
        key_n = 1'b1; step();
        key_n = 1'b0; repeat (3) step();
        key_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            check("lit_pb_held", held1, 1'b0);
            check("lit_pb_press", press1, 1'b0);
        end

        // Reset while in RELEASE_WAIT
        key_n = 1'b0; repeat (8) step();
        check("lit_rw_held_before", held1, 1'b1);
        key_n = 1'b1; repeat (3) step();
        check("lit_rw_still_held", held1, 1'b1);
        reset = 1'b1; step();
        check("lit_rw_held_reset", held1, 1'b0);
        check("lit_rw_rel_reset", rel1, 1'b0);
        check("lit_rw_held0_reset", held0, 1'b0);
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            check("lit_rw_no_release", rel1, 1'b0);
        end

        // Randomized key activity with occasional resets
        for (int k = 0; k < 150; k++) begin
            int len;
            key_n = ~key_n;
            len = ($urandom_range(0, 3) == 0) ? $urandom_range(15, 40) : $urandom_range(1, 6);
            repeat (len) step();
            if ($urandom_range(0, 40) == 0) begin
                reset = 1'b1;
                repeat (2) step();
                reset = 1'b0;
            end
        end
        key_n = 1'b1;
        repeat (12) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
